cluster_pmb_ctrl: RTL and testbench

SoC-domain serial controller for the cluster power-management bus (PMB).
- Accepts configuration words over a valid/ready request port.
- Drives the PMB signals: serial_in, shift_en[1:0], select_ctr[1:0] and pmbw_req[1:0].
- Sits directly upstream of the cluster level-shifter wrapper; its outputs connect 1:1 to that wrapper's CLUSTER_PMB_* inputs.
- Serializes each word MSB-first into one of two PMB chains, then optionally issues a write-request pulse on that chain.

---
 rtl/cluster_pmb_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_cluster_pmb_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cluster_pmb_ctrl.sv
// Purpose : serializes request words MSB-first onto one of two PMB chains, then optionally pulses pmbw_req on that chain.
// Latency : done_o rises 1 + DATA_WIDTH*CLK_DIV + 1 + REQ_CYCLES + 1 cycles after acceptance (write=1), DATA_WIDTH*CLK_DIV + 3 (write=0).
// Backpres: single outstanding transfer; req_ready_o is high only in IDLE outside reset, with no request queueing.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/_ready_o  request handshake
//   req_data_i            word to serialize (DATA_WIDTH bits)
//   req_chain_i           target chain (0/1)
//   req_ctr_i             select_ctr value for the target chain
//   req_write_i           1 = pulse pmbw_req after shifting
//   busy_o, done_o        transfer in progress / one-cycle completion pulse
//   pmb_*_o               PMB signals, 1:1 to the level-shifter wrapper inputs
module cluster_pmb_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int REQ_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic                  req_chain_i,
  input  logic                  req_ctr_i,
  input  logic                  req_write_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pmb_serial_in_o,
  output logic [1:0]            pmb_shift_en_o,
  output logic [1:0]            pmb_select_ctr_o,
  output logic [1:0]            pmb_pmbw_req_o
);

  // Counter widths: clog2 of the count range, never narrower than one bit.
  localparam int DIV_W = (CLK_DIV    > 1) ? $clog2(CLK_DIV)    : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int REQ_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(REQ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    REQ   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Request captured at acceptance; data doubles as the output shift register.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  chain;
    logic                  ctr;
    logic                  write;
  } xfer_t;

  state_t             state_q, state_d;
  xfer_t              xfer_q, xfer_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [REQ_W-1:0]   rcnt_q, rcnt_d;

  // Registered outputs
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               serial_q, serial_d;
  logic [1:0]         shift_en_q, shift_en_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         pmbw_q, pmbw_d;
  logic [1:0]         chain_oh;

  // Ready is the only output that sees rst_i directly, so requests are
  // refused in the same cycle reset is asserted.
  assign req_ready_o = (state_q == IDLE) & ~rst_i;

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    div_d   = div_q;
    bit_d   = bit_q;
    rcnt_d  = rcnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          xfer_d.data  = req_data_i;
          xfer_d.chain = req_chain_i;
          xfer_d.ctr   = req_ctr_i;
          xfer_d.write = req_write_i;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = GAP;
          end else begin
            // Advance to the next bit; the MSB of data is always the bit on the wire.
            bit_d       = bit_q + 1'b1;
            xfer_d.data = xfer_q.data << 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        rcnt_d  = '0;
        state_d = xfer_q.write ? REQ : DONE;
      end
      REQ: begin
        if (rcnt_q == REQ_LAST) begin
          state_d = DONE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values are decoded from the next state so that each registered
  // output lines up with the state it belongs to, with no combinational path
  // from req_* to the pins.
  always_comb begin
    chain_oh   = xfer_d.chain ? 2'b10 : 2'b01;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    serial_d   = 1'b0;
    shift_en_d = 2'b00;
    sel_d      = 2'b00;
    pmbw_d     = 2'b00;

    // select_ctr is held from SETUP through REQ, cleared in DONE/IDLE.
    if (state_d inside {SETUP, SHIFT, GAP, REQ}) begin
      sel_d = xfer_d.ctr ? chain_oh : 2'b00;
    end
    if (state_d == SHIFT) begin
      shift_en_d = chain_oh;
      serial_d   = xfer_d.data[DATA_WIDTH-1];
    end
    if (state_d == REQ) begin
      pmbw_d = chain_oh;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      xfer_q     <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      rcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      serial_q   <= 1'b0;
      shift_en_q <= 2'b00;
      sel_q      <= 2'b00;
      pmbw_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      xfer_q     <= xfer_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      rcnt_q     <= rcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      serial_q   <= serial_d;
      shift_en_q <= shift_en_d;
      sel_q      <= sel_d;
      pmbw_q     <= pmbw_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pmb_serial_in_o  = serial_q;
  assign pmb_shift_en_o   = shift_en_q;
  assign pmb_select_ctr_o = sel_q;
  assign pmb_pmbw_req_o   = pmbw_q;

endmodule

// File: tb/tb_cluster_pmb_ctrl.sv
// Purpose : directed bench for cluster_pmb_ctrl; per-cycle expected outputs are queued when a request is driven and popped each cycle.
// Latency : n/a (bench).
// Backpres: n/a (bench).
module tb_cluster_pmb_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default-parameter instance
  logic        a_valid, a_ready, a_chain, a_ctr, a_write;
  logic [15:0] a_data;
  logic        a_busy, a_done, a_ser;
  logic [1:0]  a_sh, a_sel, a_req;

  // Corner-parameter instance
  logic        b_valid, b_ready, b_chain, b_ctr, b_write;
  logic [0:0]  b_data;
  logic        b_busy, b_done, b_ser;
  logic [1:0]  b_sh, b_sel, b_req;

  cluster_pmb_ctrl #(.DATA_WIDTH(16), .CLK_DIV(4), .REQ_CYCLES(4)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .req_data_i(a_data),
    .req_chain_i(a_chain), .req_ctr_i(a_ctr), .req_write_i(a_write),
    .busy_o(a_busy), .done_o(a_done), .pmb_serial_in_o(a_ser),
    .pmb_shift_en_o(a_sh), .pmb_select_ctr_o(a_sel), .pmb_pmbw_req_o(a_req)
  );

  cluster_pmb_ctrl #(.DATA_WIDTH(1), .CLK_DIV(1), .REQ_CYCLES(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_data_i(b_data),
    .req_chain_i(b_chain), .req_ctr_i(b_ctr), .req_write_i(b_write),
    .busy_o(b_busy), .done_o(b_done), .pmb_serial_in_o(b_ser),
    .pmb_shift_en_o(b_sh), .pmb_select_ctr_o(b_sel), .pmb_pmbw_req_o(b_req)
  );

  // Expected vector layout: {ready, busy, done, serial, shift_en[1:0], select_ctr[1:0], pmbw_req[1:0]}
  localparam logic [9:0] IDLE_E = 10'b1000000000;
  localparam logic [9:0] ZERO_E = 10'b0000000000;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        use_b    = 1'b0;
  logic [9:0]  sb_q[$];

  function automatic int lat(int dw, int cd, int rc, logic write);
    return write ? (3 + dw * cd + rc) : (3 + dw * cd);
  endfunction

  // Expected outputs in cycle c (1 = first cycle after the accepting edge).
  function automatic logic [9:0] exp_at(int dw, int cd, int rc, logic [15:0] data,
                                        logic chain, logic ctr, logic write, int c);
    logic [1:0] oh, sh, sel, pr;
    logic       done, ser;
    int         s_end, gap, done_c, k;
    oh     = chain ? 2'b10 : 2'b01;
    s_end  = 1 + dw * cd;
    gap    = s_end + 1;
    done_c = write ? (gap + rc + 1) : (gap + 1);
    sh = 2'b00; sel = 2'b00; pr = 2'b00; done = 1'b0; ser = 1'b0;
    if (c < done_c) sel = ctr ? oh : 2'b00;
    if (c >= 2 && c <= s_end) begin
      k   = (c - 2) / cd;
      sh  = oh;
      ser = data[dw - 1 - k];
    end
    if (write && c > gap && c < done_c) pr = oh;
    if (c == done_c) done = 1'b1;
    return {1'b0, 1'b1, done, ser, sh, sel, pr};
  endfunction

  task automatic push_xfer(int dw, int cd, int rc, logic [15:0] data, logic chain,
                           logic ctr, logic write, int first, int last);
    for (int c = first; c <= last; c++) begin
      sb_q.push_back(exp_at(dw, cd, rc, data, chain, ctr, write, c));
    end
  endtask

  // Advance n cycles; sample #1 after each edge and compare to the next queued vector.
  task automatic run_cycles(int n, string tag);
    logic [9:0] obs, e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      obs = use_b ? {b_ready, b_busy, b_done, b_ser, b_sh, b_sel, b_req}
                  : {a_ready, a_busy, a_done, a_ser, a_sh, a_sel, a_req};
      n_assert++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $error("FAIL %s@%0d: scoreboard empty, observed %b required an entry", tag, cyc, obs);
      end else begin
        e = sb_q.pop_front();
        assert (obs === e) else begin
          n_fail++;
          $error("FAIL %s@%0d: observed %b expected %b", tag, cyc, obs, e);
        end
      end
    end
  endtask

  // One complete transfer on the default instance, followed by one idle cycle.
  task automatic do_a(logic [15:0] data, logic chain, logic ctr, logic write, string tag);
    int L;
    L = lat(16, 4, 4, write);
    a_data = data; a_chain = chain; a_ctr = ctr; a_write = write; a_valid = 1'b1;
    push_xfer(16, 4, 4, data, chain, ctr, write, 1, L);
    sb_q.push_back(IDLE_E);
    run_cycles(1, tag);
    // Inputs are don't-care after acceptance; scramble them.
    a_valid = 1'b0; a_data = ~data; a_chain = ~chain; a_ctr = ~ctr; a_write = ~write;
    run_cycles(L, tag);
  endtask

  initial begin
    int L1, L2;
    rst = 1'b1;
    a_valid = 1'b1; a_data = 16'hFFFF; a_chain = 1'b1; a_ctr = 1'b1; a_write = 1'b1;
    b_valid = 1'b1; b_data = 1'b1;     b_chain = 1'b1; b_ctr = 1'b1; b_write = 1'b1;

    // Reset held 3 cycles with a pending request: everything 0, ready 0.
    repeat (3) sb_q.push_back(ZERO_E);
    run_cycles(3, "reset");
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) sb_q.push_back(IDLE_E);
    run_cycles(2, "post_reset");

    // Basic write, shift-only, and a third pattern.
    do_a(16'hA5C3, 1'b1, 1'b1, 1'b1, "basic_write");
    do_a(16'h8001, 1'b0, 1'b0, 1'b0, "shift_only");
    do_a(16'h3C5A, 1'b0, 1'b1, 1'b1, "chain0_write");

    // Back-to-back with valid held high across both words.
    L1 = lat(16, 4, 4, 1'b1);
    L2 = lat(16, 4, 4, 1'b0);
    a_data = 16'h1234; a_chain = 1'b0; a_ctr = 1'b1; a_write = 1'b1; a_valid = 1'b1;
    push_xfer(16, 4, 4, 16'h1234, 1'b0, 1'b1, 1'b1, 1, L1);
    sb_q.push_back(IDLE_E);
    push_xfer(16, 4, 4, 16'hFE01, 1'b1, 1'b0, 1'b0, 1, L2);
    sb_q.push_back(IDLE_E);
    run_cycles(1, "b2b_first");
    a_data = 16'hFE01; a_chain = 1'b1; a_ctr = 1'b0; a_write = 1'b0;
    run_cycles(L1, "b2b_first");
    run_cycles(1, "b2b_second");
    a_valid = 1'b0;
    run_cycles(L2, "b2b_second");

    // Reset in cycle 30 of a write transfer.
    a_data = 16'hC0DE; a_chain = 1'b1; a_ctr = 1'b1; a_write = 1'b1; a_valid = 1'b1;
    push_xfer(16, 4, 4, 16'hC0DE, 1'b1, 1'b1, 1'b1, 1, 30);
    run_cycles(1, "mid_reset_xfer");
    a_valid = 1'b0;
    run_cycles(29, "mid_reset_xfer");
    rst = 1'b1;
    sb_q.push_back(ZERO_E);
    run_cycles(1, "mid_reset_hold");
    rst = 1'b0;
    repeat (2) sb_q.push_back(IDLE_E);
    run_cycles(2, "mid_reset_idle");
    do_a(16'h5A5A, 1'b1, 1'b0, 1'b1, "after_reset");

    // Parameter corner: DATA_WIDTH=1, CLK_DIV=1, REQ_CYCLES=1.
    use_b = 1'b1;
    sb_q.push_back(IDLE_E);
    run_cycles(1, "corner_idle");
    b_data = 1'b1; b_chain = 1'b0; b_ctr = 1'b1; b_write = 1'b1; b_valid = 1'b1;
    push_xfer(1, 1, 1, 16'h0001, 1'b0, 1'b1, 1'b1, 1, lat(1, 1, 1, 1'b1));
    sb_q.push_back(IDLE_E);
    run_cycles(1, "corner_write");
    b_valid = 1'b0; b_data = 1'b0;
    run_cycles(lat(1, 1, 1, 1'b1), "corner_write");
    b_data = 1'b0; b_chain = 1'b1; b_ctr = 1'b0; b_write = 1'b0; b_valid = 1'b1;
    push_xfer(1, 1, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1, lat(1, 1, 1, 1'b0));
    sb_q.push_back(IDLE_E);
    run_cycles(1, "corner_shift");
    b_valid = 1'b0; b_data = 1'b1;
    run_cycles(lat(1, 1, 1, 1'b0), "corner_shift");

    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
